// File: rtl/uart_arb_pkg.sv
// Shared types for the uart_tx message arbiter: FSM state encoding and byte type.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HOLD,
    ARB_SETTLE
  } arb_state_e;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: the first asserted request at or after ptr_i,
// searching circularly through N requesters.
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] winner_o
);

  localparam int IW = $clog2(N);

  int idx;

  // NOTE: every output of an always_comb gets a default before any branch; a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    any_o    = |req_i;
    winner_o = '0;
    idx      = 0;
    // Walk the offsets from farthest to nearest so the nearest hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) winner_o = IW'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte-stream requesters, granting whole messages round-robin.
// Optional stall watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [8*N_REQ-1:0]       req_data_i,
  input  logic [N_REQ-1:0]         req_last_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output byte_t                    tx_data_o,
  output logic                     tx_start_o,
  input  logic                     tx_busy_i,
  output logic                     grant_active_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o
);

  localparam int IDW = $clog2(N_REQ);

  arb_state_e     state_q;
  logic [IDW-1:0] grant_id_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic           grant_active_q;
  logic           tx_start_q;
  logic           last_q;
  byte_t          tx_data_q;
  byte_t          sel_data;
  logic           sel_valid;
  logic           sel_last;
  logic           hold_ready;
  logic           xfer;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_q;
`endif

  rr_picker #(.N(N_REQ)) u_picker (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_id)
  );

  always_comb begin
    sel_valid   = req_valid_i[grant_id_q];
    sel_last    = req_last_i[grant_id_q];
    sel_data    = req_data_i[8*grant_id_q +: 8];
    hold_ready  = (state_q == ARB_HOLD) && !tx_busy_i;
    xfer        = hold_ready && sel_valid;
    req_ready_o = '0;
    req_ready_o[grant_id_q] = hold_ready;
    rr_ptr_d    = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
  end

  // NOTE: registered state is updated with non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ARB_IDLE;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      rr_ptr_q       <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      last_q         <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timer_q        <= '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_id_q     <= pick_id;
            grant_active_q <= 1'b1;
            state_q        <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (xfer) begin
            tx_data_q  <= sel_data;
            tx_start_q <= 1'b1;
            last_q     <= sel_last;
            state_q    <= ARB_SETTLE;
`ifdef UART_ARB_TIMEOUT_EN
            timer_q    <= '0;
          end else if (!sel_valid) begin
            // A stalled owner is released exactly like the end of a message.
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
              state_q        <= ARB_IDLE;
              grant_active_q <= 1'b0;
              rr_ptr_q       <= rr_ptr_d;
              timer_q        <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
`endif
          end
        end
        ARB_SETTLE: begin
          // One dead cycle lets uart_tx raise busy before the next HOLD samples it.
          tx_start_q <= 1'b0;
          if (last_q) begin
            state_q        <= ARB_IDLE;
            grant_active_q <= 1'b0;
            rr_ptr_q       <= rr_ptr_d;
          end else begin
            state_q <= ARB_HOLD;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign tx_data_o      = tx_data_q;
  assign tx_start_o     = tx_start_q;
  assign grant_active_o = grant_active_q;
  assign grant_id_o     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a busy model of uart_tx,
// and a scoreboard of expected (grant, byte) pairs popped on every tx_start.
module tb_uart_tx_arbiter;

  localparam int N = 2;

  typedef struct packed { logic [7:0] data; logic last; } item_t;
  typedef struct packed { logic [7:0] gid;  logic [7:0] data; } exp_t;
  typedef struct {
    logic [1:0] valid;
    logic       exp_ga;
    logic [7:0] exp_gid;
    logic [1:0] exp_ready;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_last = '0;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         grant_active;
  logic [0:0]   grant_id;

  item_t q0[$];
  item_t q1[$];
  exp_t  sb[$];
  vec_t  vecs[4];

  int   n_checks = 0;
  int   n_pass = 0;
  int   start_count = 0;
  int   bcnt = 0;
  logic force_busy = 1'b0;
  logic prev_start = 1'b0;
  logic s_ga = 1'b0;
  logic [0:0] s_gid = '0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .tx_data_o      (tx_data),
    .tx_start_o     (tx_start),
    .tx_busy_i      (tx_busy),
    .grant_active_o (grant_active),
    .grant_id_o     (grant_id)
  );

  always #5 clk = ~clk;

  // uart_tx model: busy rises the cycle after start is sampled and stays up 10 cycles.
  always @(posedge clk) begin
    if (rst) bcnt <= 0;
    else if (tx_start) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || force_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    if (q0.size() != 0) begin
      req_valid[0]    = 1'b1;
      req_data[7:0]   = q0[0].data;
      req_last[0]     = q0[0].last;
    end
    if (q1.size() != 0) begin
      req_valid[1]    = 1'b1;
      req_data[15:8]  = q1[0].data;
      req_last[1]     = q1[0].last;
    end
  endtask

  // One clock: monitor at the falling edge, advance requester queues after the rising edge.
  task automatic step();
    logic [N-1:0] fire;
    exp_t e;
    @(negedge clk);
    fire  = req_valid & req_ready;
    s_ga  = grant_active;
    s_gid = grant_id;
    if (tx_start) begin
      start_count++;
      check("start_one_cycle", {31'd0, prev_start}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
        check("tx_grant_id", {31'd0, grant_id}, {24'd0, e.gid});
        check("tx_grant_active", {31'd0, grant_active}, 32'd1);
      end
    end
    prev_start = tx_start;
    @(posedge clk);
    #1;
    if (fire[0] && q0.size() != 0) void'(q0.pop_front());
    if (fire[1] && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    force_busy = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_count = 0;
    prev_start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !grant_active && bcnt == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  function automatic exp_t mk(input int gid, input logic [7:0] d);
    mk.gid  = 8'(gid);
    mk.data = d;
  endfunction

  function automatic item_t it(input logic [7:0] d, input logic l);
    it.data = d;
    it.last = l;
  endfunction

  initial begin
    int hold;

    // Reset state
    do_reset();
    check("rst_grant_active", {31'd0, grant_active}, 32'd0);
    check("rst_grant_id", {31'd0, grant_id}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);

    // Grant selection from IDLE with rr_ptr=0
    vecs[0] = '{valid: 2'b00, exp_ga: 1'b0, exp_gid: 8'd0, exp_ready: 2'b00};
    vecs[1] = '{valid: 2'b01, exp_ga: 1'b1, exp_gid: 8'd0, exp_ready: 2'b01};
    vecs[2] = '{valid: 2'b10, exp_ga: 1'b1, exp_gid: 8'd1, exp_ready: 2'b10};
    vecs[3] = '{valid: 2'b11, exp_ga: 1'b1, exp_gid: 8'd0, exp_ready: 2'b01};
    for (int v = 0; v < 4; v++) begin
      do_reset();
      if (vecs[v].valid[0]) q0.push_back(it(8'hC0, 1'b1));
      if (vecs[v].valid[1]) q1.push_back(it(8'hC1, 1'b1));
      drive();
      check($sformatf("vec%0d_idle_ready", v), {30'd0, req_ready}, 32'd0);
      step();
      check($sformatf("vec%0d_grant_active", v), {31'd0, grant_active}, {31'd0, vecs[v].exp_ga});
      check($sformatf("vec%0d_grant_id", v), {31'd0, grant_id}, {24'd0, vecs[v].exp_gid});
      check($sformatf("vec%0d_hold_ready", v), {30'd0, req_ready}, {30'd0, vecs[v].exp_ready});
    end

    // 1. Two-byte message from req0
    do_reset();
    q0.push_back(it(8'h48, 1'b0));
    q0.push_back(it(8'h69, 1'b1));
    sb.push_back(mk(0, 8'h48));
    sb.push_back(mk(0, 8'h69));
    drive();
    drain("t1_drain", 200);
    check("t1_starts", start_count, 32'd2);
    check("t1_released", {31'd0, grant_active}, 32'd0);

    // 2. Both requesters with 3-byte messages: no interleave
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(it(8'hA1 + 8'(i), i == 2));
      q1.push_back(it(8'hB1 + 8'(i), i == 2));
    end
    for (int i = 0; i < 3; i++) sb.push_back(mk(0, 8'hA1 + 8'(i)));
    for (int i = 0; i < 3; i++) sb.push_back(mk(1, 8'hB1 + 8'(i)));
    drive();
    drain("t2_drain", 400);
    check("t2_starts", start_count, 32'd6);

    // 3. Single-byte messages, 4 rounds: strict alternation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(it(8'h10 + 8'(i), 1'b1));
      q1.push_back(it(8'h20 + 8'(i), 1'b1));
      sb.push_back(mk(0, 8'h10 + 8'(i)));
      sb.push_back(mk(1, 8'h20 + 8'(i)));
    end
    drive();
    drain("t3_drain", 600);
    check("t3_starts", start_count, 32'd8);

    // 4. Busy held high for 20 cycles while granted
    begin
      logic bad = 1'b0;
      do_reset();
      force_busy = 1'b1;
      q0.push_back(it(8'hA5, 1'b1));
      sb.push_back(mk(0, 8'hA5));
      drive();
      step();
      check("t4_granted", {31'd0, grant_active}, 32'd1);
      for (int i = 0; i < 20; i++) begin
        if (req_ready != '0) bad = 1'b1;
        step();
      end
      check("t4_no_ready", {31'd0, bad}, 32'd0);
      check("t4_no_start", start_count, 32'd0);
      force_busy = 1'b0;
      drain("t4_drain", 200);
      check("t4_sent_once", start_count, 32'd1);
    end

    // 5. Reset mid-message of req1
    do_reset();
    q0.push_back(it(8'h01, 1'b1));
    sb.push_back(mk(0, 8'h01));
    drive();
    drain("t5_pre_drain", 200);
    q1.push_back(it(8'h11, 1'b0));
    q1.push_back(it(8'h22, 1'b0));
    q1.push_back(it(8'h33, 1'b1));
    sb.push_back(mk(1, 8'h11));
    drive();
    start_count = 0;
    for (int i = 0; i < 50 && start_count < 1; i++) step();
    check("t5_first_byte", start_count, 32'd1);
    for (int i = 0; i < 3; i++) step();
    check("t5_mid_grant_id", {31'd0, grant_id}, 32'd1);
    do_reset();
    check("t5_rst_grant_active", {31'd0, grant_active}, 32'd0);
    check("t5_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("t5_rst_grant_id", {31'd0, grant_id}, 32'd0);
    check("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("t5_sb_empty", sb.size(), 32'd0);
    // rr_ptr back at 0: req0 wins the tie, then req1 is served cleanly
    q0.push_back(it(8'hA0, 1'b1));
    q1.push_back(it(8'h5A, 1'b1));
    sb.push_back(mk(0, 8'hA0));
    sb.push_back(mk(1, 8'h5A));
    drive();
    drain("t5_drain", 300);
    check("t5_starts", start_count, 32'd2);

`ifdef UART_ARB_TIMEOUT_EN
    // 6. Requester stalls mid-message: forced release after 16 idle HOLD cycles
    do_reset();
    q0.push_back(it(8'h77, 1'b0));
    q1.push_back(it(8'h88, 1'b1));
    sb.push_back(mk(0, 8'h77));
    sb.push_back(mk(1, 8'h88));
    drive();
    for (int i = 0; i < 50 && start_count < 1; i++) step();
    check("t6_first_byte", start_count, 32'd1);
    hold = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!(s_ga && s_gid == 1'b0)) break;
      hold++;
    end
    check("t6_hold_cycles", hold, 32'd16);
    drain("t6_drain", 200);
    check("t6_starts", start_count, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
